imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Sequencer and two-port arbiter in front of the 8-bit instruction memory. It shares the memory's single address/data/rw port between a program loader, which writes, and the fetch unit, which reads. It also owns the memory's rw line, so no requester can cause a spurious write. It sits between the loader/fetch logic and `instruction_memory`, and drives that memory's `add`, `ip` and `rw` inputs directly.

## Interface
- `AW`, default 8: address width.
- `DW`, default 8: data width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `ld_req` in 1: loader write request; held until granted.
- `ld_addr` in AW: loader write address.
- `ld_data` in DW: loader write data.
- `ld_gnt` out 1: one-cycle pulse; loader address and data captured on this edge.
- `fe_req` in 1: fetch read request; held until granted.
- `fe_addr` in AW: fetch read address.
- `fe_gnt` out 1: one-cycle pulse; fetch address captured on this edge.
- `fe_rdata` out DW: read data, valid while `fe_rvalid`=1.
- `fe_rvalid` out 1: one-cycle pulse.
- `mem_add` out AW: to memory `add`.
- `mem_ip` out DW: to memory `ip`.
- `mem_rw` out 1: to memory `rw`; 0 = write, 1 = read.
- `mem_op` in DW: from memory `op`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE, no request: stay in IDLE; `mem_rw`=1; `mem_add` and `mem_ip` hold their last values.
- IDLE, request present: pick a winner.
  - Register `mem_add` and `mem_ip` from the winner's inputs.
  - Set `mem_rw` (0 for loader, 1 for fetch).
  - Pulse the winner's gnt.
  - Go to WRITE (loader) or READ (fetch).
- WRITE: memory writes on this edge. Then `mem_rw`←1 and go to IDLE.
- READ: memory samples `mem_add`. Go to RESP.
- RESP: `fe_rdata`←`mem_op`, `fe_rvalid` pulses, go to IDLE.
- Only the granted requester ever drives the memory; the loser keeps `req` high and waits.
- A `req` still high in the cycle after gnt counts as a new request at the next IDLE. Requesters drop `req` on seeing gnt.
- No wrap or overflow: addresses pass through unchanged across the full 0..2^AW−1 range.
- Reset, asynchronous assert: all outputs take their reset values immediately and the FSM goes to IDLE. An in-flight read is dropped without `fe_rvalid`. An in-flight write is abandoned with `mem_rw` forced to 1.
- Reset values:
  - `mem_rw`=1.
  - `mem_add`=0, `mem_ip`=0.
  - `ld_gnt`=0, `fe_gnt`=0, `fe_rvalid`=0.
  - `fe_rdata`=0, `busy`=0.
  - Round-robin pointer set to loader-last, so fetch wins the first tie.

## Timing
- Request sampled in IDLE at edge N:
  - gnt is high during cycle N..N+1.
  - Memory signals are valid from N.
- Write: memory captures at edge N+1; back in IDLE at N+1.
  - Back-to-back writes are spaced 2 cycles apart.
- Read: `fe_rvalid` and `fe_rdata` are valid from edge N+2 for one cycle.
  - Back in IDLE at N+2, so requests are serviced every 3 cycles.
- The memory is taken to present `op` one clock after the address is registered.
- Requests that arrive while `busy`=1 are not sampled until IDLE.

## Configuration
- `IMEM_ARB_RR_EN` defined: round-robin.
  - When both requests are present, the requester not served last wins.
  - The pointer updates only on a grant.
- `IMEM_ARB_RR_EN` undefined: fixed priority, loader always wins.
  - Fetch can starve while the loader streams; this is acceptable during program load.
- The pointer flop exists only when the macro is defined.

## Structure
- Package `imem_arb_pkg` holds:
  - State enum `imem_arb_state_t` (IDLE, WRITE, READ, RESP).
  - Constants `RW_WRITE`=1'b0 and `RW_READ`=1'b1.
  - Requester id constants `REQ_LD`, `REQ_FE`.
- One sub-module, `imem_arb_pick`: combinational two-way winner select plus the optional round-robin pointer register.
- The FSM and output registers stay in `imem_arbiter`.

## Test plan
- Reset: hold `reset`=0 for 3 cycles. Expect `mem_rw`=1, all gnt/valid signals 0, `mem_add`=0 and `busy`=0.
- Loader writes 0xF8, 0xF9, 0xFA to addresses 0x01, 0x02, 0x03.
  - Expect three `ld_gnt` pulses 2 cycles apart.
  - `mem_rw`=0 for exactly one cycle per write.
- Fetch reads 0x01..0x03 after that load.
  - `fe_rvalid` is 2 cycles after each `fe_gnt`.
  - `fe_rdata` is 0xF8, 0xF9, 0xFA in order.
- Simultaneous `ld_req` and `fe_req` held continuously (write addr 0x10 data 0x55, read addr 0x01):
  - With `IMEM_ARB_RR_EN`: grants alternate FE, LD, FE, LD.
  - Without the macro: LD is granted every IDLE and FE never is.
- Reset mid-read: drop `reset` in the READ state.
  - Expect no `fe_rvalid`, `mem_rw`=1 immediately and FSM in IDLE.
  - Then a fresh read of 0x02 returns 0xF9.
- Address extremes: write/read 0x00 and 0xFF with data 0xA5/0x5A. Read-back must match with no aliasing.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Optional feature macro: IMEM_ARB_RR_EN (round-robin arbitration).
package imem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } imem_arb_state_t;

    // Memory rw line encoding.
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Requester identifiers, also used as the round-robin pointer value.
    localparam logic REQ_LD = 1'b0;
    localparam logic REQ_FE = 1'b1;

    // Round-robin tie break: the requester not served last wins.
    function automatic logic rr_winner(input logic last_id);
        logic win_s;
        if (last_id == REQ_LD) begin
            win_s = REQ_FE;
        end else begin
            win_s = REQ_LD;
        end
        return win_s;
    endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Two-way winner select between loader and fetch.
// With IMEM_ARB_RR_EN defined, ties are broken round-robin using a
// last-served pointer; otherwise the loader has fixed priority.
module imem_arb_pick
    import imem_arb_pkg::*;
(
`ifdef IMEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic upd_en,
`endif
    input  logic ld_req,
    input  logic fe_req,
    output logic win_ld,
    output logic win_fe
);

`ifdef IMEM_ARB_RR_EN
    logic last_q;
    logic last_d;
    logic tie_id_s;

    // Winner select and pointer update; the pointer moves only on a grant.
    always_comb begin
        win_ld   = 1'b0;
        win_fe   = 1'b0;
        last_d   = last_q;
        tie_id_s = rr_winner(last_q);
        if (ld_req && fe_req) begin
            if (tie_id_s == REQ_FE) begin
                win_fe = 1'b1;
            end else begin
                win_ld = 1'b1;
            end
        end else if (ld_req) begin
            win_ld = 1'b1;
        end else if (fe_req) begin
            win_fe = 1'b1;
        end else begin
            win_ld = 1'b0;
            win_fe = 1'b0;
        end
        if (upd_en && win_ld) begin
            last_d = REQ_LD;
        end else if (upd_en && win_fe) begin
            last_d = REQ_FE;
        end else begin
            last_d = last_q;
        end
    end

    // Last-served pointer; resets to loader so fetch wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= REQ_LD;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: loader always wins; fetch may starve during load.
    always_comb begin
        win_ld = 1'b0;
        win_fe = 1'b0;
        if (ld_req) begin
            win_ld = 1'b1;
        end else if (fe_req) begin
            win_fe = 1'b1;
        end else begin
            win_ld = 1'b0;
            win_fe = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Sequencer/arbiter sharing the single instruction-memory port between
// the program loader (writes) and the fetch unit (reads). Owns mem_rw so
// that only a granted loader cycle can ever write.
// Optional feature macro: IMEM_ARB_RR_EN (round-robin instead of loader priority).
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_gnt,
    input  logic          fe_req,
    input  logic [AW-1:0] fe_addr,
    output logic          fe_gnt,
    output logic [DW-1:0] fe_rdata,
    output logic          fe_rvalid,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_ip,
    output logic          mem_rw,
    input  logic [DW-1:0] mem_op,
    output logic          busy
);

    imem_arb_state_t state_q, state_d;
    logic [AW-1:0]   mem_add_q, mem_add_d;
    logic [DW-1:0]   mem_ip_q, mem_ip_d;
    logic            mem_rw_q, mem_rw_d;
    logic            ld_gnt_q, ld_gnt_d;
    logic            fe_gnt_q, fe_gnt_d;
    logic [DW-1:0]   fe_rdata_q, fe_rdata_d;
    logic            fe_rvalid_q, fe_rvalid_d;
    logic            busy_q, busy_d;

    logic            idle_s;
    logic            win_ld_s;
    logic            win_fe_s;

    assign idle_s = (state_q == IDLE);

    imem_arb_pick u_pick (
`ifdef IMEM_ARB_RR_EN
        .clk    (clk),
        .reset  (reset),
        .upd_en (idle_s),
`endif
        .ld_req (ld_req),
        .fe_req (fe_req),
        .win_ld (win_ld_s),
        .win_fe (win_fe_s)
    );

    // Next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        state_d     = state_q;
        mem_add_d   = mem_add_q;
        mem_ip_d    = mem_ip_q;
        mem_rw_d    = mem_rw_q;
        ld_gnt_d    = 1'b0;
        fe_gnt_d    = 1'b0;
        fe_rdata_d  = fe_rdata_q;
        fe_rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                mem_rw_d = RW_READ;
                if (win_ld_s) begin
                    mem_add_d = ld_addr;
                    mem_ip_d  = ld_data;
                    mem_rw_d  = RW_WRITE;
                    ld_gnt_d  = 1'b1;
                    state_d   = WRITE;
                end else if (win_fe_s) begin
                    mem_add_d = fe_addr;
                    mem_rw_d  = RW_READ;
                    fe_gnt_d  = 1'b1;
                    state_d   = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                // Memory captures on this edge; release the write strobe.
                mem_rw_d = RW_READ;
                state_d  = IDLE;
            end
            READ: begin
                mem_rw_d = RW_READ;
                state_d  = RESP;
            end
            RESP: begin
                mem_rw_d    = RW_READ;
                fe_rdata_d  = mem_op;
                fe_rvalid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                mem_rw_d = RW_READ;
                state_d  = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_add_q   <= {AW{1'b0}};
            mem_ip_q    <= {DW{1'b0}};
            mem_rw_q    <= RW_READ;
            ld_gnt_q    <= 1'b0;
            fe_gnt_q    <= 1'b0;
            fe_rdata_q  <= {DW{1'b0}};
            fe_rvalid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_add_q   <= mem_add_d;
            mem_ip_q    <= mem_ip_d;
            mem_rw_q    <= mem_rw_d;
            ld_gnt_q    <= ld_gnt_d;
            fe_gnt_q    <= fe_gnt_d;
            fe_rdata_q  <= fe_rdata_d;
            fe_rvalid_q <= fe_rvalid_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_add   = mem_add_q;
    assign mem_ip    = mem_ip_q;
    assign mem_rw    = mem_rw_q;
    assign ld_gnt    = ld_gnt_q;
    assign fe_gnt    = fe_gnt_q;
    assign fe_rdata  = fe_rdata_q;
    assign fe_rvalid = fe_rvalid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter with a behavioural instruction
// memory and a read-data scoreboard.
module tb_imem_arbiter;

    logic       clk;
    logic       reset;
    logic       ld_req;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_gnt;
    logic       fe_req;
    logic [7:0] fe_addr;
    logic       fe_gnt;
    logic [7:0] fe_rdata;
    logic       fe_rvalid;
    logic [7:0] mem_add;
    logic [7:0] mem_ip;
    logic       mem_rw;
    logic [7:0] mem_op;
    logic       busy;

    int test_cnt;
    int fail_cnt;
    int cyc;
    int last_fe_gnt_cyc;
    bit log_en;

    logic [7:0] exp_q[$];
    byte        grant_log[$];
    logic [7:0] mem_arr [256];

    imem_arbiter #(.AW(8), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_gnt    (ld_gnt),
        .fe_req    (fe_req),
        .fe_addr   (fe_addr),
        .fe_gnt    (fe_gnt),
        .fe_rdata  (fe_rdata),
        .fe_rvalid (fe_rvalid),
        .mem_add   (mem_add),
        .mem_ip    (mem_ip),
        .mem_rw    (mem_rw),
        .mem_op    (mem_op),
        .busy      (busy)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural instruction memory: write when rw=0, registered op.
    always @(posedge clk) begin
        if (mem_rw == 1'b0) mem_arr[mem_add] <= mem_ip;
        mem_op <= mem_arr[mem_add];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: grant log and scoreboard comparison on fe_rvalid.
    always @(negedge clk) begin
        if (fe_gnt) begin
            last_fe_gnt_cyc = cyc;
            if (log_en) grant_log.push_back(byte'("F"));
        end
        if (ld_gnt && log_en) grant_log.push_back(byte'("L"));
        if (fe_rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check("rdata", {24'd0, fe_rdata}, {24'd0, exp_q.pop_front()});
                check("rvalid_latency", 32'(cyc - last_fe_gnt_cyc), 32'd2);
            end
        end
    end

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, output int gcyc);
        int  n;
        bit  seen;
        ld_addr = a;
        ld_data = d;
        ld_req  = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (ld_gnt) seen = 1'b1;
            else n++;
        end
        check("ld_gnt_seen", {31'd0, seen}, 32'd1);
        gcyc = cyc;
        if (seen) begin
            check("wr_rw_low", {31'd0, mem_rw}, 32'd0);
            check("wr_add", {24'd0, mem_add}, {24'd0, a});
            check("wr_ip", {24'd0, mem_ip}, {24'd0, d});
        end
        @(posedge clk);
        #1 ld_req = 1'b0;
        @(negedge clk);
        check("wr_rw_back", {31'd0, mem_rw}, 32'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
        int n;
        bit seen;
        exp_q.push_back(exp);
        fe_addr = a;
        fe_req  = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (fe_gnt) seen = 1'b1;
            else n++;
        end
        check("fe_gnt_seen", {31'd0, seen}, 32'd1);
        if (seen) check("rd_add", {24'd0, mem_add}, {24'd0, a});
        @(posedge clk);
        #1 fe_req = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rw", {31'd0, mem_rw}, 32'd1);
        check("rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
        check("rst_fe_gnt", {31'd0, fe_gnt}, 32'd0);
        check("rst_rvalid", {31'd0, fe_rvalid}, 32'd0);
        check("rst_mem_add", {24'd0, mem_add}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        int g0, g1, g2;
        byte exp_order[$];
        int n;
        test_cnt = 0;
        fail_cnt = 0;
        cyc = 0;
        last_fe_gnt_cyc = 0;
        log_en = 1'b0;
        ld_req = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
        fe_req = 1'b0; fe_addr = 8'h00;
        reset = 1'b0;

        // Reset state.
        apply_reset();
        check("rst_mem_ip", {24'd0, mem_ip}, 32'd0);
        check("rst_rdata", {24'd0, fe_rdata}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back loader writes.
        do_write(8'h01, 8'hF8, g0);
        do_write(8'h02, 8'hF9, g1);
        do_write(8'h03, 8'hFA, g2);
        check("ld_gnt_spacing_1", 32'(g1 - g0), 32'd2);
        check("ld_gnt_spacing_2", 32'(g2 - g1), 32'd2);

        // Fetch reads of the loaded program.
        do_read(8'h01, 8'hF8);
        do_read(8'h02, 8'hF9);
        do_read(8'h03, 8'hFA);
        repeat (4) @(posedge clk);
        #1;

        // Simultaneous requests held continuously, from a fresh pointer.
        apply_reset();
        @(posedge clk);
        #1;
`ifdef IMEM_ARB_RR_EN
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'hF8);
        exp_order = '{byte'("F"), byte'("L"), byte'("F"), byte'("L")};
`else
        exp_order = '{byte'("L"), byte'("L"), byte'("L"), byte'("L"), byte'("L")};
`endif
        grant_log.delete();
        log_en  = 1'b1;
        ld_addr = 8'h10; ld_data = 8'h55; ld_req = 1'b1;
        fe_addr = 8'h01; fe_req = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        ld_req = 1'b0;
        fe_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        log_en = 1'b0;
        check("grant_count", 32'(grant_log.size()), 32'(exp_order.size()));
        n = (grant_log.size() < exp_order.size()) ? grant_log.size() : exp_order.size();
        for (int i = 0; i < n; i++) begin
            check("grant_order", 32'(grant_log[i]), 32'(exp_order[i]));
        end

        // Reset while a read is in flight.
        fe_addr = 8'h02;
        fe_req  = 1'b1;
        n = 0;
        while (!fe_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_rd_gnt_seen", {31'd0, fe_gnt}, 32'd1);
        #1 reset = 1'b0;
        fe_req = 1'b0;
        #1;
        check("mid_rd_mem_rw", {31'd0, mem_rw}, 32'd1);
        check("mid_rd_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_read(8'h02, 8'hF9);

        // Address extremes.
        repeat (3) @(posedge clk);
        #1;
        do_write(8'h00, 8'hA5, g0);
        do_write(8'hFF, 8'h5A, g1);
        do_read(8'h00, 8'hA5);
        do_read(8'hFF, 8'h5A);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
